i2s_stereo_tx: RTL and testbench

I2S_STEREO_TX -- requirements
Module: i2s_stereo_tx

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_gain.sv | 50 +++++
 rtl/i2s_stereo_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_i2s_stereo_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared constants for the I2S stereo transmitter.
// Holds the serial-format mode encodings and the default parameter
// values used by i2s_stereo_tx and its gain stage.
package i2s_pkg;

    // Default audio sample width in bits (signed two's complement).
    localparam int WIDTH_DEF     = 24;
    // Default number of bck periods per channel slot.
    localparam int SLOT_BITS_DEF = 32;
    // Default number of clk cycles per bck half-period.
    localparam int BCK_DIV_DEF   = 3;

    // Serial format selection, sampled on the mode input.
    localparam logic MODE_I2S = 1'b0;   // Philips: MSB one bck after ws edge
    localparam logic MODE_LJ  = 1'b1;   // left-justified: MSB on the ws edge

endpackage

// File: rtl/i2s_gain.sv
// i2s_gain -- combinational per-channel volume/mute stage.
// Ports:
//   sample    in  WIDTH  signed input sample
//   vol_shift in  4      attenuation as arithmetic right shift 0..15
//   mute      in  1      force a zero result
//   result    out WIDTH  rounded, shifted, saturated sample
module i2s_gain
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [3:0]       vol_shift,
    input  logic             mute,
    output logic [WIDTH-1:0] result
);

    // 16 guard bits keep the rounding constant (up to 2^14) representable
    // even for very narrow sample widths.
    localparam int EW = WIDTH + 16;
    localparam logic signed [EW-1:0] MAX_S = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_S = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [EW-1:0] ext_s;
    logic signed [EW-1:0] rnd_s;
    logic signed [EW-1:0] sum_s;
    logic signed [EW-1:0] shr_s;

    // Round-half-up, arithmetic shift, then clamp back into WIDTH bits.
    always_comb begin
        ext_s = EW'($signed(sample));
        if (vol_shift != 4'd0) begin
            rnd_s = EW'(32'sd1) << (vol_shift - 4'd1);
        end else begin
            rnd_s = '0;
        end
        sum_s = ext_s + rnd_s;
        shr_s = sum_s >>> vol_shift;
        if (mute) begin
            result = '0;
        end else if (shr_s > MAX_S) begin
            result = MAX_S[WIDTH-1:0];
        end else if (shr_s < MIN_S) begin
            result = MIN_S[WIDTH-1:0];
        end else begin
            result = shr_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx -- stereo I2S / left-justified serial transmitter.
// Ports:
//   clk, rst                   system clock, async active-high reset
//   in_valid/in_ready          sample-pair handshake into a one-deep holding register
//   left_sample, right_sample  signed WIDTH-bit channel samples
//   mute, vol_shift, mode      frame controls, latched at each frame start
//   bck, ws, data              serial audio outputs (all registered, clk domain)
//   underrun                   one-clk pulse when a frame starts with no pair held
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int BCK_DIV   = BCK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left_sample,
    input  logic [WIDTH-1:0] right_sample,
    input  logic             mute,
    input  logic [3:0]       vol_shift,
    input  logic             mode,
    output logic             bck,
    output logic             ws,
    output logic             data,
    output logic             underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam int DW         = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int I2S_SH     = SLOT_BITS - 1 - WIDTH;
    localparam int LJ_SH      = SLOT_BITS - WIDTH;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

    if (SLOT_BITS < WIDTH + 1) begin : g_bad_slot
        $error("i2s_stereo_tx: SLOT_BITS must be at least WIDTH+1");
    end
    if (BCK_DIV < 1) begin : g_bad_div
        $error("i2s_stereo_tx: BCK_DIV must be at least 1");
    end

    logic [DW-1:0]        div_cnt_r;
    logic                 bck_r;
    logic [CW-1:0]        bit_cnt_r;
    logic                 ws_r;
    logic                 data_r;
    logic                 underrun_r;
    logic                 hold_valid_r;
    logic [WIDTH-1:0]     hold_left_r;
    logic [WIDTH-1:0]     hold_right_r;
    logic [WIDTH-1:0]     frame_left_r;
    logic [WIDTH-1:0]     frame_right_r;
    logic                 mode_r;

    logic                 tick_s;
    logic                 fall_s;
    logic                 frame_start_s;
    logic                 accept_s;
    logic [CW-1:0]        bit_next_s;
    logic [WIDTH-1:0]     gain_left_s;
    logic [WIDTH-1:0]     gain_right_s;
    logic [WIDTH-1:0]     frame_left_next_s;
    logic [WIDTH-1:0]     frame_right_next_s;
    logic                 mode_next_s;
    logic                 chan_s;
    logic [CW-1:0]        k_s;
    logic [WIDTH-1:0]     samp_s;
    logic [SLOT_BITS-1:0] slot_s;
    logic                 ws_next_s;
    logic                 data_next_s;

    assign tick_s        = (div_cnt_r == DIV_LAST);
    assign fall_s        = tick_s & bck_r;
    assign frame_start_s = fall_s & (bit_next_s == '0);
    assign accept_s      = in_valid & ~hold_valid_r;

    assign in_ready = ~hold_valid_r;
    assign bck      = bck_r;
    assign ws       = ws_r;
    assign data     = data_r;
    assign underrun = underrun_r;

    // Gain is applied as the pair leaves the holding register, using the
    // mute/vol_shift values present at frame start, so the frame registers
    // already carry the final serial words and the controls need no latch.
    i2s_gain #(.WIDTH(WIDTH)) u_gain_left (
        .sample    (hold_left_r),
        .vol_shift (vol_shift),
        .mute      (mute),
        .result    (gain_left_s)
    );

    i2s_gain #(.WIDTH(WIDTH)) u_gain_right (
        .sample    (hold_right_r),
        .vol_shift (vol_shift),
        .mute      (mute),
        .result    (gain_right_s)
    );

    // Bit position that the coming fall event moves to, wrapping per frame.
    always_comb begin
        if (bit_cnt_r == LAST_BIT) begin
            bit_next_s = '0;
        end else begin
            bit_next_s = bit_cnt_r + CW'(32'd1);
        end
    end

    // Frame contents after this cycle; on frame start the new values are
    // used immediately so the LJ MSB appears together with bit_cnt 0.
    always_comb begin
        frame_left_next_s  = frame_left_r;
        frame_right_next_s = frame_right_r;
        mode_next_s        = mode_r;
        if (frame_start_s) begin
            mode_next_s = mode;
            if (hold_valid_r) begin
                frame_left_next_s  = gain_left_s;
                frame_right_next_s = gain_right_s;
            end else begin
                frame_left_next_s  = '0;
                frame_right_next_s = '0;
            end
        end else begin
            mode_next_s = mode_r;
        end
    end

    // Serializer: place the sample MSB-first in a slot-wide word whose bit
    // SLOT_BITS-1 corresponds to slot position k = 0, then pick position k.
    always_comb begin
        chan_s = (bit_next_s >= SLOT_LEN);
        if (chan_s) begin
            k_s    = bit_next_s - SLOT_LEN;
            samp_s = frame_right_next_s;
        end else begin
            k_s    = bit_next_s;
            samp_s = frame_left_next_s;
        end
        if (mode_next_s == MODE_I2S) begin
            slot_s    = SLOT_BITS'(samp_s) << I2S_SH;
            // ws leads the data by one bck in Philips format
            ws_next_s = ~((bit_next_s == LAST_BIT) |
                          (bit_next_s <= (SLOT_LEN - CW'(32'd2))));
        end else begin
            slot_s    = SLOT_BITS'(samp_s) << LJ_SH;
            ws_next_s = chan_s;
        end
        data_next_s = 1'b0;
        for (int i = 0; i < SLOT_BITS; i++) begin
            data_next_s = (k_s == CW'(SLOT_BITS - 1 - i)) ? slot_s[i] : data_next_s;
        end
    end

    // bck divider: toggle every BCK_DIV clk cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            bck_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            bck_r     <= ~bck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(32'd1);
        end
    end

    // Serial outputs and bit position advance only on bck falling events;
    // bit_cnt resets to the last position so the first fall starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= LAST_BIT;
            ws_r      <= 1'b0;
            data_r    <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_next_s;
            ws_r      <= ws_next_s;
            data_r    <= data_next_s;
        end
    end

    // Frame registers and format latch, loaded once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_left_r  <= '0;
            frame_right_r <= '0;
            mode_r        <= MODE_I2S;
        end else begin
            frame_left_r  <= frame_left_next_s;
            frame_right_r <= frame_right_next_s;
            mode_r        <= mode_next_s;
        end
    end

    // Holding register: a pair accepted in the frame-start cycle is only
    // possible when it was empty, so nothing is consumed and it simply fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_left_r  <= '0;
            hold_right_r <= '0;
        end else if (accept_s) begin
            hold_valid_r <= 1'b1;
            hold_left_r  <= left_sample;
            hold_right_r <= right_sample;
        end else if (frame_start_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Underrun flag, aligned with the serial outputs of the frame-start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= frame_start_s & ~hold_valid_r;
        end
    end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// tb_i2s_stereo_tx -- scoreboard bench for i2s_stereo_tx with default
// parameters. The driver predicts, from frame timing arithmetic and a
// one-deep holding model, the complete 64-bit ws/data pattern of each
// frame and queues it; a monitor decodes the serial lines on bck falling
// edges and compares bit by bit.
module tb_i2s_stereo_tx;
    import i2s_pkg::*;

    localparam int W     = 24;
    localparam int SB    = 32;
    localparam int DIV   = 3;
    localparam int FB    = 2 * SB;
    localparam int FRAME = FB * 2 * DIV;

    typedef struct {
        bit          ur;
        logic [63:0] ws;
        logic [63:0] dat;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] left_sample = '0;
    logic [W-1:0] right_sample = '0;
    logic         mute = 1'b0;
    logic [3:0]   vol_shift = 4'd0;
    logic         mode = MODE_I2S;
    logic         bck, ws, data, underrun;

    frame_t       exp_q[$];
    logic [47:0]  hold_q[$];
    int           vectors = 0;
    int           fails = 0;
    int           t = 0;
    int           model_bit = -1;

    // bench-side wishes, applied to the DUT inputs only inside step()
    bit           feed_en = 1'b0, use_fixed = 1'b1, rand_ctrl = 1'b0, rand_valid = 1'b0;
    logic [W-1:0] fix_l = '0, fix_r = '0;
    logic         w_mode = MODE_I2S, w_mute = 1'b0;
    logic [3:0]   w_vol = 4'd0;

    always #5 clk = ~clk;

    i2s_stereo_tx #(.WIDTH(W), .SLOT_BITS(SB), .BCK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .mute         (mute),
        .vol_shift    (vol_shift),
        .mode         (mode),
        .bck          (bck),
        .ws           (ws),
        .data         (data),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // volume model in plain integer arithmetic
    function automatic logic [W-1:0] gain_ref(input logic [W-1:0] x, input logic [3:0] v, input logic m);
        longint s, r;
        s = longint'($signed(x));
        if (m) r = 0;
        else if (v == 4'd0) r = s;
        else r = (s + (longint'(1) << (v - 4'd1))) >>> v;
        if (r > 64'sd8388607) r = 64'sd8388607;
        if (r < -64'sd8388608) r = -64'sd8388608;
        return r[W-1:0];
    endfunction

    // expected ws/data for every bit position of one frame
    function automatic frame_t build(input logic [W-1:0] l, input logic [W-1:0] r, input logic md, input bit ur);
        frame_t f;
        logic [W-1:0] s;
        int k;
        f.ur = ur;
        for (int b = 0; b < FB; b++) begin
            k = b % SB;
            s = (b < SB) ? l : r;
            if (md == MODE_I2S) begin
                f.ws[b]  = (b == FB - 1 || b <= SB - 2) ? 1'b0 : 1'b1;
                f.dat[b] = (k >= 1 && k <= W) ? s[W - k] : 1'b0;
            end else begin
                f.ws[b]  = (b < SB) ? 1'b0 : 1'b1;
                f.dat[b] = (k < W) ? s[W - 1 - k] : 1'b0;
            end
        end
        return f;
    endfunction

    // One clk cycle: release reset if pending, check in_ready, drive inputs,
    // and advance the model for the coming rising edge.
    task automatic step();
        bit accept;
        logic [47:0] p;
        @(negedge clk);
        if (rst) begin
            rst = 1'b0;
            t = 0;
            model_bit = -1;
            hold_q.delete();
            exp_q.delete();
        end
        check("in_ready", in_ready, hold_q.size() == 0);
        if (rand_ctrl && $urandom_range(0, 299) == 0) begin
            w_mode = 1'($urandom_range(0, 1));
            w_mute = ($urandom_range(0, 3) == 0);
            w_vol  = 4'($urandom_range(0, 15));
        end
        mode      = w_mode;
        mute      = w_mute;
        vol_shift = w_vol;
        in_valid  = feed_en && (!rand_valid || $urandom_range(0, 1) == 1);
        left_sample  = use_fixed ? fix_l : W'($urandom);
        right_sample = use_fixed ? fix_r : W'($urandom);
        t++;
        accept = in_valid && hold_q.size() == 0;
        if (t % (2 * DIV) == 0) begin
            model_bit = ((t / (2 * DIV)) - 1) % FB;
            if (model_bit == 0) begin
                if (hold_q.size() > 0) begin
                    p = hold_q.pop_front();
                    exp_q.push_back(build(gain_ref(p[47:24], vol_shift, mute),
                                          gain_ref(p[23:0], vol_shift, mute), mode, 1'b0));
                end else begin
                    exp_q.push_back(build('0, '0, mode, 1'b1));
                end
            end
        end
        if (accept) hold_q.push_back({left_sample, right_sample});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_bit(input int b);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (model_bit != b && n < 2 * FRAME);
        if (model_bit != b) begin
            vectors++;
            fails++;
            $display("FAIL wait_bit_%0d: timed out after %0d cycles", b, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bck"}, bck, 1'b0);
        check({tag, "_ws"}, ws, 1'b0);
        check({tag, "_data"}, data, 1'b0);
        check({tag, "_underrun"}, underrun, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    // Monitor: decode the serial stream on bck falling edges.
    initial begin : monitor
        frame_t cur;
        bit have, first, prev_bck;
        int idx, since;
        have = 0; first = 1; prev_bck = 0; idx = 0; since = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                have = 0; first = 1; prev_bck = 0; idx = 0; since = 0;
            end else begin
                since++;
                if (prev_bck && !bck) begin
                    if (!first) check("bck_period", since, 2 * DIV);
                    first = 0;
                    since = 0;
                    if (idx == 0) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            fails++;
                            have = 0;
                            $display("FAIL frame_start: got a frame start expected none queued");
                        end else begin
                            cur = exp_q.pop_front();
                            have = 1;
                        end
                    end
                    if (have) begin
                        if (idx == 0) check("underrun", underrun, cur.ur);
                        else check("underrun_mid", underrun, 1'b0);
                        check($sformatf("ws[%0d]", idx), ws, cur.ws[idx]);
                        check($sformatf("data[%0d]", idx), data, cur.dat[idx]);
                    end
                    idx = (idx + 1) % FB;
                end else begin
                    check("underrun_idle", underrun, 1'b0);
                end
                prev_bck = bck;
            end
        end
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");

        // I2S, extreme-ish patterns, unity gain
        feed_en = 1; use_fixed = 1;
        fix_l = 24'h800001; fix_r = 24'h7FFFFE;
        w_mode = MODE_I2S; w_mute = 0; w_vol = 4'd0;
        run(3 * FRAME);

        // left-justified
        w_mode = MODE_LJ; fix_l = 24'hA5A5A5; fix_r = 24'h3C3C3C;
        run(2 * FRAME);

        // rounding without overflow, and rounding of -1 to zero
        w_mode = MODE_I2S; w_vol = 4'd1; fix_l = 24'h7FFFFF; fix_r = 24'h800000;
        run(2 * FRAME);
        w_vol = 4'd4; fix_l = 24'hFFFFFF; fix_r = 24'h123456;
        run(2 * FRAME);
        w_vol = 4'd0;

        // starve the transmitter for more than a frame
        feed_en = 0;
        run(2 * FRAME + FRAME / 2);
        feed_en = 1;
        run(FRAME);

        // mute mid-frame: takes effect only from the next frame
        wait_bit(10);
        w_mute = 1;
        run(2 * FRAME);
        w_mute = 0;
        run(FRAME);

        // randomized data, valid and controls
        use_fixed = 0; rand_valid = 1; rand_ctrl = 1;
        run(6 * FRAME);
        rand_ctrl = 0; rand_valid = 0;
        w_mode = MODE_I2S; w_mute = 0; w_vol = 4'd0;

        // reset in the middle of the right slot
        wait_bit(40);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        in_valid = 1'b0;
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
